// File: rtl/fpga_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// fpga_pll_lock_supervisor
//
// Supervises the 125 MHz Ethernet PLL from the free-running 200 MHz reference
// clock domain. Pulses the PLL reset, synchronises the asynchronous LOCKED
// output, qualifies lock stability and then releases the Ethernet reset
// request. A lock timeout or a lock loss re-pulses the PLL. Two saturating
// event counters are exposed for firmware.
//
// Ports
//   clk          in   1      200 MHz free-running reference clock
//   rst          in   1      synchronous active-high reset
//   pll_locked   in   1      PLL LOCKED (asynchronous to clk)
//   pll_rst_n    out  1      to PLL rst_n; 0 = PLL held in reset
//   eth_rst      out  1      active-high reset request for the eth_pll_clk domain
//   eth_ready    out  1      1 = PLL locked and qualified (state RUN)
//   lost_cnt     out  CNT_W  lock-loss events seen in RUN, saturating
//   timeout_cnt  out  CNT_W  WAIT_LOCK timeouts, saturating
// -----------------------------------------------------------------------------
module fpga_pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned PLL_RST_CYC      = 64,
    parameter int unsigned LOCK_TIMEOUT_CYC = 20000,
    parameter int unsigned STABLE_CYC       = 2048,
    parameter int unsigned CNT_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst_n,
    output logic             eth_rst,
    output logic             eth_ready,
    output logic [CNT_W-1:0] lost_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fpga_pll_lock_supervisor: SYNC_STAGES must be >= 2");
    end
    if (PLL_RST_CYC == 0) begin : g_bad_rst_cyc
        $error("fpga_pll_lock_supervisor: PLL_RST_CYC must be >= 1");
    end
    if (LOCK_TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("fpga_pll_lock_supervisor: LOCK_TIMEOUT_CYC must be >= 1");
    end
    if (STABLE_CYC == 0) begin : g_bad_stable
        $error("fpga_pll_lock_supervisor: STABLE_CYC must be >= 1");
    end

    // ------------------------------------------------------------------
    // Timer sizing: one shared timer wide enough for the longest interval
    // ------------------------------------------------------------------
    localparam int unsigned MAX_AB  = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ?
                                      PLL_RST_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned MAX_CYC = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic                   pll_rst_n_q, pll_rst_n_d;
    logic                   eth_rst_q, eth_rst_d;
    logic                   eth_ready_q, eth_ready_d;
    logic [CNT_W-1:0]       lost_cnt_q, lost_cnt_d;
    logic [CNT_W-1:0]       timeout_cnt_q, timeout_cnt_d;

    logic                   lost_evt;
    logic                   timeout_evt;

    // ------------------------------------------------------------------
    // LOCKED synchroniser (shift towards the MSB, MSB is the safe output)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State / timer / output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PLL_RST;
            timer_q       <= '0;
            pll_rst_n_q   <= 1'b0;
            eth_rst_q     <= 1'b1;
            eth_ready_q   <= 1'b0;
            lost_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            pll_rst_n_q   <= pll_rst_n_d;
            eth_rst_q     <= eth_rst_d;
            eth_ready_q   <= eth_ready_d;
            lost_cnt_q    <= lost_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lost_evt    = 1'b0;
        timeout_evt = 1'b0;

        unique case (state_q)
            PLL_RST: begin
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle still wins.
                if (locked_s) begin
                    state_d = STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d     = PLL_RST;
                    timeout_evt = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d  = PLL_RST;
                    lost_evt = 1'b1;
                end
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        // Timer restarts on every state change; it is idle in RUN.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == RUN) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output logic: outputs are registered copies decoded from the next
    // state so they change on the same edge as the transition.
    // ------------------------------------------------------------------
    always_comb begin
        pll_rst_n_d   = (state_d != PLL_RST);
        eth_rst_d     = (state_d != RUN);
        eth_ready_d   = (state_d == RUN);
        lost_cnt_d    = lost_cnt_q;
        timeout_cnt_d = timeout_cnt_q;

        if (lost_evt && (lost_cnt_q != '1)) begin
            lost_cnt_d = lost_cnt_q + CNT_W'(1);
        end
        if (timeout_evt && (timeout_cnt_q != '1)) begin
            timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        end
    end

    assign pll_rst_n   = pll_rst_n_q;
    assign eth_rst     = eth_rst_q;
    assign eth_ready   = eth_ready_q;
    assign lost_cnt    = lost_cnt_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_fpga_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_fpga_pll_lock_supervisor
//
// Directed bench for fpga_pll_lock_supervisor with small cycle parameters.
// A phase/elapsed-count model tracks what the outputs must be every cycle;
// directed steps additionally pin edge counts and counter values by hand.
// -----------------------------------------------------------------------------
module tb_fpga_pll_lock_supervisor;

    localparam int SYNC = 2;
    localparam int PRC  = 4;
    localparam int LTO  = 50;
    localparam int STC  = 10;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int LIM  = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          pll_rst_n;
    logic          eth_rst;
    logic          eth_ready;
    logic [CW-1:0] lost_cnt;
    logic [CW-1:0] timeout_cnt;

    int tests = 0;
    int fails = 0;

    fpga_pll_lock_supervisor #(
        .SYNC_STAGES      (SYNC),
        .PLL_RST_CYC      (PRC),
        .LOCK_TIMEOUT_CYC (LTO),
        .STABLE_CYC       (STC),
        .CNT_W            (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst_n   (pll_rst_n),
        .eth_rst     (eth_rst),
        .eth_ready   (eth_ready),
        .lost_cnt    (lost_cnt),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model. Phases: 0 = PLL held in reset, 1 = searching for lock,
    // 2 = qualifying lock, 3 = running. 'el' counts edges spent in phase.
    // hist[] holds the last SYNC samples of pll_locked, oldest last.
    // ------------------------------------------------------------------
    int m_phase = 0;
    int m_el    = 0;
    int m_hist[SYNC];
    int m_lost  = 0;
    int m_to    = 0;
    bit m_on    = 1'b0;

    always @(posedge clk) begin
        int ls;
        if (rst) begin
            m_phase = 0;
            m_el    = 0;
            m_lost  = 0;
            m_to    = 0;
            for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
            m_on    = 1'b1;
        end else begin
            ls = m_hist[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = int'(pll_locked);
            case (m_phase)
                0: begin
                    m_el++;
                    if (m_el == PRC) begin m_phase = 1; m_el = 0; end
                end
                1: begin
                    if (ls != 0) begin
                        m_phase = 2; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == LTO) begin
                            m_phase = 0; m_el = 0;
                            m_to = (m_to < CMAX) ? m_to + 1 : CMAX;
                        end
                    end
                end
                2: begin
                    if (ls == 0) begin
                        m_phase = 1; m_el = 0;
                    end else begin
                        m_el++;
                        if (m_el == STC) begin m_phase = 3; m_el = 0; end
                    end
                end
                default: begin
                    if (ls == 0) begin
                        m_phase = 0; m_el = 0;
                        m_lost = (m_lost < CMAX) ? m_lost + 1 : CMAX;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            chk("mdl_pll_rst_n",   32'(pll_rst_n),   32'(m_phase != 0));
            chk("mdl_eth_rst",     32'(eth_rst),     32'(m_phase != 3));
            chk("mdl_eth_ready",   32'(eth_ready),   32'(m_phase == 3));
            chk("mdl_lost_cnt",    32'(lost_cnt),    32'(m_lost));
            chk("mdl_timeout_cnt", 32'(timeout_cnt), 32'(m_to));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic sel(input int s);
        case (s)
            0:       return pll_rst_n;
            1:       return eth_rst;
            default: return eth_ready;
        endcase
    endfunction

    // Edges until the selected output shows v (bounded; LIM means expired).
    task automatic edges_until(input int s, input logic v, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sel(s) !== v && n < LIM);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst_n"},   32'(pll_rst_n),   0);
        chk({tag, "_eth_rst"},     32'(eth_rst),     1);
        chk({tag, "_eth_ready"},   32'(eth_ready),   0);
        chk({tag, "_lost_cnt"},    32'(lost_cnt),    0);
        chk({tag, "_timeout_cnt"}, 32'(timeout_cnt), 0);
    endtask

    initial begin : watchdog
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        bit drop;

        // 1: reset, then PLL reset pulse of PRC edges
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (5) tick();
        chk_reset_vals("t1_rst");
        rst = 1'b0;
        edges_until(0, 1'b1, n);
        chk("t1_pll_rst_edges", 32'(n), 4);
        chk("t1_eth_rst_held", 32'(eth_rst), 1);

        // 2: lock arrives 10 cycles into WAIT_LOCK
        repeat (10) tick();
        pll_locked = 1'b1;
        edges_until(1, 1'b0, n);
        chk("t2_lock_to_release", 32'(n), SYNC + 1 + 10);
        chk("t2_eth_ready", 32'(eth_ready), 1);
        chk("t2_lost_cnt", 32'(lost_cnt), 0);
        chk("t2_timeout_cnt", 32'(timeout_cnt), 0);

        // 4: lock drop of 3 cycles in RUN
        repeat (5) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        chk("t4_eth_rst_pre", 32'(eth_rst), 0);
        tick();
        chk("t4_eth_rst_post", 32'(eth_rst), 1);
        chk("t4_pll_rst_n_low", 32'(pll_rst_n), 0);
        chk("t4_lost_cnt", 32'(lost_cnt), 1);
        pll_locked = 1'b1;
        edges_until(0, 1'b1, n);
        chk("t4_pll_rst_len", 32'(n), 4);
        edges_until(1, 1'b0, n);
        chk("t4_requal", 32'(n), 1 + STC);

        // 5: second loss (lost_cnt=2), then glitch during qualification at timer=7
        repeat (5) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        chk("t5_lost_cnt", 32'(lost_cnt), 2);
        pll_locked = 1'b1;
        edges_until(0, 1'b1, n);
        chk("t5_pll_rst_len", 32'(n), 4);
        repeat (8) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        n = 0;
        drop = 1'b0;
        do begin
            tick();
            n++;
            if (pll_rst_n !== 1'b1) drop = 1'b1;
        end while (eth_rst !== 1'b0 && n < LIM);
        chk("t5_requal_edges", 32'(n), 13);
        chk("t5_pll_rst_n_held", 32'(drop), 0);
        chk("t5_lost_unchanged", 32'(lost_cnt), 2);
        chk("t5_timeout_cnt", 32'(timeout_cnt), 0);

        // 6: one-cycle reset from RUN with lost_cnt=2
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("t6_rst");
        edges_until(0, 1'b1, n);
        chk("t6_pll_rst_edges", 32'(n), 4);
        edges_until(1, 1'b0, n);
        chk("t6_requal", 32'(n), 1 + STC);

        // 3: lock lost and never returns -> periodic re-pulse, saturating timeouts
        pll_locked = 1'b0;
        repeat (3) tick();
        chk("t3_lost_cnt", 32'(lost_cnt), 1);
        edges_until(0, 1'b1, n);
        chk("t3_first_pulse", 32'(n), 4);
        for (int k = 1; k <= 4; k++) begin
            edges_until(0, 1'b0, n);
            chk("t3_wait_len", 32'(n), LTO);
            chk("t3_timeout_cnt", 32'(timeout_cnt), 32'((k < 3) ? k : 3));
            edges_until(0, 1'b1, n);
            chk("t3_pulse_len", 32'(n), PRC);
        end
        chk("t3_eth_rst", 32'(eth_rst), 1);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
